// File: rtl/adder_ctrl_pkg.sv
// Shared types for the checked-adder retry controller: FSM states and response codes.
package adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_CORR  = 2'b01;
    localparam logic [1:0] ST_INERR = 2'b10;
    localparam logic [1:0] ST_FATAL = 2'b11;

endpackage

// File: rtl/operand_code_check.sv
// Input pre-check: odd overall parity across operands+parity bit, and a one-hot code word.
module operand_code_check (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       par,
    input  logic [2:0] code,
    output logic       ok
);

    logic parity_ok;
    logic onehot_ok;

    assign parity_ok = ^{a, b, par};
    assign onehot_ok = (code != 3'b000) && ((code & (code - 3'd1)) == 3'b000);
    assign ok        = parity_ok && onehot_ok;

endmodule

// File: rtl/adder_retry_ctrl.sv
// Issues operands to an external two-rail checked adder, samples after settling, retries on error.
module adder_retry_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int MAX_RETRY     = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_a,
    input  logic [2:0] req_b,
    input  logic       req_par,
    input  logic [2:0] req_code,
    output logic [2:0] add_a,
    output logic [2:0] add_b,
    output logic       add_par,
    output logic [2:0] add_code,
    input  logic [2:0] add_sum,
    input  logic       add_cout,
    input  logic       add_e0,
    input  logic       add_e1,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_sum,
    output logic       rsp_cout,
    output logic [1:0] rsp_status,
    output logic [1:0] rsp_tries,
    output logic       busy,
    output logic       perm_fault,
    output logic [7:0] fault_count
);

    localparam logic [1:0] SETTLE_INIT = 2'(SETTLE_CYCLES - 1);
    localparam logic [1:0] RETRY_MAX   = 2'(MAX_RETRY);

    state_t     state;
    logic [1:0] settle;
    logic [1:0] tries;
    logic       in_ok;
    logic       sample_pass;

    operand_code_check u_check (
        .a    (req_a),
        .b    (req_b),
        .par  (req_par),
        .code (req_code),
        .ok   (in_ok)
    );

    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign rsp_valid   = (state == RESP);
    assign sample_pass = (add_e0 != add_e1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            settle      <= '0;
            tries       <= '0;
            add_a       <= '0;
            add_b       <= '0;
            add_par     <= 1'b0;
            add_code    <= '0;
            rsp_sum     <= '0;
            rsp_cout    <= 1'b0;
            rsp_status  <= ST_OK;
            rsp_tries   <= '0;
            perm_fault  <= 1'b0;
            fault_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (in_ok) begin
                            add_a    <= req_a;
                            add_b    <= req_b;
                            add_par  <= req_par;
                            add_code <= req_code;
                            settle   <= SETTLE_INIT;
                            tries    <= '0;
                            state    <= ISSUE;
                        end else begin
                            // Bad operands never reach the adder; report directly.
                            rsp_sum    <= '0;
                            rsp_cout   <= 1'b0;
                            rsp_status <= ST_INERR;
                            rsp_tries  <= '0;
                            state      <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    if (settle != 2'd0) begin
                        settle <= settle - 2'd1;
                    end else if (sample_pass) begin
                        rsp_sum    <= add_sum;
                        rsp_cout   <= add_cout;
                        rsp_status <= (tries == 2'd0) ? ST_OK : ST_CORR;
                        rsp_tries  <= tries;
                        state      <= RESP;
                    end else begin
                        fault_count <= (fault_count == 8'hFF) ? 8'hFF : fault_count + 8'd1;
                        if (tries < RETRY_MAX) begin
                            tries  <= tries + 2'd1;
                            settle <= SETTLE_INIT;
                        end else begin
                            rsp_sum    <= add_sum;
                            rsp_cout   <= add_cout;
                            rsp_status <= ST_FATAL;
                            rsp_tries  <= tries;
                            perm_fault <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/adder_retry_ctrl.md
ADDER_RETRY_CTRL -- requirements
Module: adder_retry_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 2, meaning re-issues allowed after a failed attempt (0..3).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1, meaning cycles operands are held before sampling (1..4).
REQ-003 SHALL have one clock and a synchronous active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have these request ports: req_valid in 1; req_ready out 1; req_a in 3; req_b in 3; req_par in 1 (parity bit); req_code in 3 ({C2,C1,C0}).
REQ-005 SHALL have these checked-adder ports: add_a out 3; add_b out 3; add_par out 1; add_code out 3; add_sum in 3; add_cout in 1; add_e0 in 1; add_e1 in 1 (two-rail error pair).
REQ-006 SHALL have these response ports: rsp_valid out 1; rsp_ready in 1; rsp_sum out 3; rsp_cout out 1; rsp_status out 2 (00 ok, 01 corrected by retry, 10 input code error, 11 uncorrectable); rsp_tries out 2 (attempts minus 1).
REQ-007 SHALL have these status ports: busy out 1; perm_fault out 1 (sticky); fault_count out 8 (saturating).

Function
REQ-008 SHALL implement states IDLE, ISSUE, RESP; req_ready=1 only in IDLE; busy=1 in ISSUE or RESP.
REQ-009 SHALL accept a request on a clk edge with req_valid&req_ready and register req_a/b/par/code onto add_a/b/par/code, holding them stable until the next acceptance.
REQ-010 SHALL pre-check the input: valid iff XOR(req_a,req_b,req_par)=1 and req_code has exactly one bit set; if invalid, go IDLE->RESP with status 10, sum/cout 0, tries 0, and no issue.
REQ-011 SHALL, on a valid acceptance, go to ISSUE with the settle counter loaded to SETTLE_CYCLES-1 and the try counter at 0.
REQ-012 SHALL, in ISSUE, decrement the settle counter each cycle and sample add_sum/add_cout/add_e0/add_e1 on the edge where the counter is 0.
REQ-013 SHALL treat a sample as passing iff add_e0 != add_e1, and as failing iff add_e0 == add_e1.
REQ-014 SHALL, on a pass, go to RESP with the sampled sum/cout and status 00 when tries=0, or 01 when tries>0.
REQ-015 SHALL, on a fail with tries<MAX_RETRY, increment tries, reload the settle counter, and stay in ISSUE.
REQ-016 SHALL, on a fail with tries=MAX_RETRY, go to RESP with status 11 and the last sampled sum/cout, and set perm_fault.
REQ-017 SHALL increment fault_count by 1 on every failing sample, saturating at 255.
REQ-018 SHALL latency: with SETTLE_CYCLES=1 and a first-try pass, assert rsp_valid 2 cycles after the accepting edge; each retry adds SETTLE_CYCLES cycles.
REQ-019 SHALL, in RESP, hold rsp_valid=1 and all rsp_* stable until rsp_valid&rsp_ready, then go to IDLE; req_ready SHALL stay 0 in the handshake cycle (no same-cycle accept).
REQ-020 SHALL drive rsp_valid=0 outside RESP.
REQ-021 SHALL drive rsp_tries = the final try counter value, which never exceeds MAX_RETRY.
REQ-022 SHALL ignore req_* while not in IDLE.

Reset
REQ-023 SHALL, while rst=1 on a clk edge, go to IDLE and set add_a, add_b, add_par, add_code, rsp_sum, rsp_cout, rsp_status, rsp_tries, fault_count and all counters to 0, perm_fault=0 and rsp_valid=0; req_ready SHALL be 1 in the cycle after reset.
REQ-024 SHALL abandon an in-flight request on reset mid-operation (any state), with no response produced.
REQ-025 SHALL give rst priority over every simultaneous handshake.

Structure
REQ-026 SHALL take the state enum and rsp_status codes (ST_OK, ST_CORR, ST_INERR, ST_FATAL) from shared package adder_ctrl_pkg.
REQ-027 SHALL put the combinational parity/one-hot pre-check in one sub-module, operand_code_check.

Verification
REQ-028 SHALL cover: a=3, b=2, par=0, code=001, model e0/e1=1/0, sum=5 -> rsp 2 cycles later with sum=5, status 00, tries 0, fault_count 0.
REQ-029 SHALL cover: model fails the first sample then passes -> status 01, tries 1, fault_count 1, perm_fault 0.
REQ-030 SHALL cover: model always returns e0=e1=1 with MAX_RETRY=2 -> status 11, tries 2, fault_count 3, perm_fault 1.
REQ-031 SHALL cover: code=011 or parity even (a=1, b=0, par=1) -> status 10 next cycle, add_* unchanged, fault_count unchanged.
REQ-032 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_* stable and req_ready 0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-033 SHALL cover: rst asserted in ISSUE during a retry -> all outputs 0, no rsp_valid; 300 forced fails -> fault_count=255.
